// File: rtl/fir_coef_loader_if.sv
// rtl/fir_coef_loader_if.sv - coefficient beat stream between a source and the loader
interface fir_coef_loader_if #(
    parameter int COEFW = 18
);
    logic [COEFW-1:0] s_coef_data;
    logic             s_coef_valid;
    logic             s_coef_ready;

    modport master (
        output s_coef_data,
        output s_coef_valid,
        input  s_coef_ready
    );

    modport slave (
        input  s_coef_data,
        input  s_coef_valid,
        output s_coef_ready
    );
endinterface

// File: rtl/fir_coef_loader.sv
// rtl/fir_coef_loader.sv - shadow/active coefficient bank loader for the FIR tap chain
module fir_coef_loader #(
    parameter int NTAPS = 16,
    parameter int COEFW = 18,
    parameter int IDXW  = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_start,
    fir_coef_loader_if.slave       coef,
    input  logic                   sample_stb,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   restart_err,
    output logic [NTAPS*COEFW-1:0] coef_out
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD      = 2'd1,
        WAIT_SWAP = 2'd2
    } state_t;

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NTAPS - 1);

    state_t           state;
    state_t           state_nxt;
    logic [IDXW-1:0]  idx;
    logic [COEFW-1:0] shadow [NTAPS];
    logic [COEFW-1:0] active [NTAPS];

    logic beat;
    logic restart;
    logic commit;

    // A restart in LOAD takes priority over a coincident beat, so the beat is dropped.
    assign beat    = (state == LOAD) && coef.s_coef_valid && !load_start;
    assign restart = (state == LOAD) && load_start;
    assign commit  = (state == WAIT_SWAP) && sample_stb;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (load_start) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (!load_start && beat && (idx == LAST_IDX)) begin
                    state_nxt = WAIT_SWAP;
                end
            end
            WAIT_SWAP: begin
                if (sample_stb) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Ready and busy decode straight from the state register, so they are glitch-free.
    always_comb begin
        coef.s_coef_ready = 1'b0;
        load_busy         = 1'b0;
        case (state)
            IDLE: begin
                coef.s_coef_ready = 1'b0;
                load_busy         = 1'b0;
            end
            LOAD: begin
                coef.s_coef_ready = 1'b1;
                load_busy         = 1'b1;
            end
            WAIT_SWAP: begin
                coef.s_coef_ready = 1'b0;
                load_busy         = 1'b1;
            end
            default: begin
                coef.s_coef_ready = 1'b0;
                load_busy         = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx         <= '0;
            load_done   <= 1'b0;
            restart_err <= 1'b0;
            for (int k = 0; k < NTAPS; k++) begin
                shadow[k] <= '0;
                active[k] <= '0;
            end
        end else begin
            load_done   <= commit;
            restart_err <= restart;

            if (load_start && (state != WAIT_SWAP)) begin
                idx <= '0;
            end else if (beat) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + IDXW'(1);
            end

            // Decoded write keeps the index compare at full counter width.
            if (beat) begin
                for (int k = 0; k < NTAPS; k++) begin
                    if (idx == IDXW'(k)) begin
                        shadow[k] <= coef.s_coef_data;
                    end
                end
            end

            if (commit) begin
                for (int k = 0; k < NTAPS; k++) begin
                    active[k] <= shadow[k];
                end
            end
        end
    end

    for (genvar g = 0; g < NTAPS; g++) begin : g_coef_out
        assign coef_out[g*COEFW +: COEFW] = active[g];
    end

endmodule

// File: tb/tb_fir_coef_loader.sv
// tb/tb_fir_coef_loader.sv - scoreboard bench for fir_coef_loader
module tb_fir_coef_loader;
    localparam int NTAPS = 16;
    localparam int COEFW = 18;
    localparam int IDXW  = 5;
    localparam int FLATW = NTAPS * COEFW;

    logic             clk;
    logic             rst;
    logic             load_start;
    logic             sample_stb;
    logic             load_busy;
    logic             load_done;
    logic             restart_err;
    logic [FLATW-1:0] coef_out;

    fir_coef_loader_if #(.COEFW(COEFW)) cif ();

    fir_coef_loader #(
        .NTAPS (NTAPS),
        .COEFW (COEFW),
        .IDXW  (IDXW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_start  (load_start),
        .coef        (cif),
        .sample_stb  (sample_stb),
        .load_busy   (load_busy),
        .load_done   (load_done),
        .restart_err (restart_err),
        .coef_out    (coef_out)
    );

    int total = 0;
    int bad   = 0;

    logic [FLATW-1:0] exp_q[$];
    int               restart_q[$];
    logic [COEFW-1:0] vals [NTAPS];
    logic [FLATW-1:0] active_model;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [FLATW-1:0] act, input logic [FLATW-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    function automatic logic [FLATW-1:0] pack_vals();
        logic [FLATW-1:0] p;
        p = '0;
        for (int k = 0; k < NTAPS; k++) begin
            p[k*COEFW +: COEFW] = vals[k];
        end
        return p;
    endfunction

    // Monitor: every load_done / restart_err pulse must match a queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (load_done) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL load_done_unexpected: got pulse expected none");
                end else begin
                    check("commit_coef_out", coef_out, exp_q.pop_front());
                    check("busy_at_done", FLATW'(load_busy), FLATW'(0));
                end
            end
            if (restart_err) begin
                if (restart_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL restart_err_unexpected: got pulse expected none");
                end else begin
                    total++;
                    void'(restart_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic send_beat(input logic [COEFW-1:0] d, input bit stb);
        int n;
        n = 0;
        cif.s_coef_data  = d;
        cif.s_coef_valid = 1'b1;
        while (!cif.s_coef_ready && n < 50) begin
            tick();
            n++;
        end
        if (!cif.s_coef_ready) begin
            total++;
            bad++;
            $display("FAIL beat_ready_timeout: got ready=0 expected 1");
        end
        sample_stb = stb;
        tick();
        sample_stb       = 1'b0;
        cif.s_coef_valid = 1'b0;
    endtask

    task automatic send_set(input bit gaps, input bit stb_last);
        for (int k = 0; k < NTAPS; k++) begin
            send_beat(vals[k], stb_last && (k == NTAPS - 1));
            if (gaps && k != NTAPS - 1) begin
                tick();
            end
        end
        check("ready_after_last", FLATW'(cif.s_coef_ready), FLATW'(0));
        check("busy_wait_swap", FLATW'(load_busy), FLATW'(1));
    endtask

    task automatic do_commit();
        exp_q.push_back(pack_vals());
        active_model = pack_vals();
        sample_stb = 1'b1;
        tick();
        sample_stb = 1'b0;
        check("done_after_stb", FLATW'(load_done), FLATW'(1));
        tick();
        check("done_one_cycle", FLATW'(load_done), FLATW'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst              = 1'b1;
        load_start       = 1'b0;
        sample_stb       = 1'b0;
        cif.s_coef_data  = '0;
        cif.s_coef_valid = 1'b0;
        active_model     = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_coef_out", coef_out, '0);
        check("reset_ready", FLATW'(cif.s_coef_ready), FLATW'(0));
        check("reset_busy", FLATW'(load_busy), FLATW'(0));
        check("reset_done", FLATW'(load_done), FLATW'(0));
        check("reset_err", FLATW'(restart_err), FLATW'(0));

        // 1: continuous stream 1..16, stb 5 cycles after last beat
        for (int k = 0; k < NTAPS; k++) vals[k] = COEFW'(k + 1);
        pulse_start();
        check("busy_in_load", FLATW'(load_busy), FLATW'(1));
        check("ready_in_load", FLATW'(cif.s_coef_ready), FLATW'(1));
        send_set(1'b0, 1'b0);
        repeat (4) tick();
        check("hold_before_stb1", coef_out, '0);
        do_commit();

        // 2: valid toggling every other cycle
        for (int k = 0; k < NTAPS; k++) vals[k] = COEFW'(200 + 3 * k);
        pulse_start();
        send_set(1'b1, 1'b0);
        do_commit();

        // 3: all ones, then a withheld commit of 100..115
        for (int k = 0; k < NTAPS; k++) vals[k] = '1;
        pulse_start();
        send_set(1'b0, 1'b0);
        do_commit();
        for (int k = 0; k < NTAPS; k++) vals[k] = COEFW'(100 + k);
        pulse_start();
        send_set(1'b0, 1'b0);
        repeat (10) tick();
        check("hold_all_ones", coef_out, {FLATW{1'b1}});
        do_commit();

        // 4: restart after 7 beats, coincident with a dropped beat
        pulse_start();
        for (int k = 0; k < 7; k++) send_beat(COEFW'(500 + k), 1'b0);
        restart_q.push_back(1);
        cif.s_coef_data  = 18'h155;
        cif.s_coef_valid = 1'b1;
        load_start       = 1'b1;
        tick();
        load_start       = 1'b0;
        cif.s_coef_valid = 1'b0;
        check("busy_after_restart", FLATW'(load_busy), FLATW'(1));
        for (int k = 0; k < NTAPS; k++) vals[k] = 18'h2A;
        send_set(1'b0, 1'b0);
        pulse_start();
        check("start_ignored_wait", FLATW'(load_busy), FLATW'(1));
        do_commit();

        // 5: stb on the final beat does not commit
        for (int k = 0; k < NTAPS; k++) vals[k] = COEFW'(18'h20000 + 7 * k);
        pulse_start();
        send_set(1'b0, 1'b1);
        repeat (9) tick();
        check("no_commit_coincident", coef_out, active_model);
        check("still_waiting", FLATW'(load_busy), FLATW'(1));
        do_commit();

        // 6: reset in WAIT_SWAP, then a normal load
        for (int k = 0; k < NTAPS; k++) vals[k] = COEFW'(900 + k);
        pulse_start();
        send_set(1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        active_model = '0;
        check("rst_coef_out", coef_out, '0);
        check("rst_busy", FLATW'(load_busy), FLATW'(0));
        repeat (3) tick();
        for (int k = 0; k < NTAPS; k++) vals[k] = COEFW'(40 + 2 * k);
        pulse_start();
        send_set(1'b0, 1'b0);
        do_commit();

        repeat (5) tick();
        check("exp_q_drained", FLATW'(exp_q.size()), FLATW'(0));
        check("restart_q_drained", FLATW'(restart_q.size()), FLATW'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
